// File: rtl/wb_user_port_responder.sv
// Wishbone classic-cycle responder standing in for a 256-bit LiteDRAM user
// port. Requests complete after a fixed latency with a one-cycle ack, or
// with a one-cycle err for addresses beyond the modelled array.
module wb_user_port_responder #(
  parameter int DATA_WIDTH    = 256,
  parameter int ADDR_WIDTH    = 25,
  parameter int DEPTH_LOG2    = 10,
  parameter int WRITE_LATENCY = 2,
  parameter int READ_LATENCY  = 4,
  parameter int INIT_DELAY    = 64
) (
  input  logic                    user_clk,
  input  logic                    user_rst,
  input  logic [ADDR_WIDTH-1:0]   wb_adr,
  input  logic [DATA_WIDTH-1:0]   wb_dat_w,
  output logic [DATA_WIDTH-1:0]   wb_dat_r,
  input  logic [DATA_WIDTH/8-1:0] wb_sel,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  output logic                    wb_ack,
  output logic                    wb_err,
  output logic                    init_done,
  output logic                    init_error
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << DEPTH_LOG2;

  // Latency counter preloads; a load of 0 skips BUSY entirely.
  localparam logic [3:0]  WR_LOAD   = 4'(WRITE_LATENCY - 1);
  localparam logic [3:0]  RD_LOAD   = 4'(READ_LATENCY - 1);
  localparam logic [15:0] INIT_LAST = 16'(INIT_DELAY - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             init_cnt_q, init_cnt_d;
  logic [3:0]              lat_cnt_q, lat_cnt_d;
  logic [DEPTH_LOG2-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    err_q, err_d;
  logic                    init_done_q, init_done_d;
  logic [DATA_WIDTH-1:0]   dat_r_q;
  logic                    rd_en;
  logic                    wr_en;
  logic                    out_of_range;
  logic [3:0]              lat_load;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign out_of_range = |wb_adr[ADDR_WIDTH-1:DEPTH_LOG2];
  assign lat_load     = wb_we ? WR_LOAD : RD_LOAD;

  // Next-state logic: init countdown, request capture, latency countdown, abort.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    err_d       = err_q;
    init_done_d = init_done_q;
    rd_en       = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 16'd1;
        end
      end

      ST_IDLE: begin
        if (wb_cyc && wb_stb) begin
          adr_d = wb_adr[DEPTH_LOG2-1:0];
          dat_d = wb_dat_w;
          sel_d = wb_sel;
          we_d  = wb_we;
          if (out_of_range) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d     = 1'b0;
            lat_cnt_d = lat_load;
            state_d   = (lat_load == 4'd0) ? ST_RESP : ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        if (!wb_cyc) begin
          // Initiator gave up: drop the request without touching the array.
          state_d = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
          if (lat_cnt_q == 4'd1) begin
            // Launch the registered array read so data lands in RESP.
            rd_en   = ~we_q;
            state_d = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        wr_en   = we_q & ~err_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_INIT;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
    end
  end

  // Byte-enabled array write; a reset landing on the RESP edge cancels it.
  always_ff @(posedge user_clk) begin
    if (wr_en && !user_rst) begin
      for (int b = 0; b < SEL_WIDTH; b++) begin
        if (sel_q[b]) begin
          mem[adr_q][b*8 +: 8] <= dat_q[b*8 +: 8];
        end
      end
    end
  end

  // Registered array read; output holds until the next read response.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      dat_r_q <= '0;
    end else if (rd_en) begin
      dat_r_q <= mem[adr_q];
    end
  end

  assign wb_dat_r   = dat_r_q;
  assign wb_ack     = (state_q == ST_RESP) && !err_q;
  assign wb_err     = (state_q == ST_RESP) && err_q;
  assign init_done  = init_done_q;
  assign init_error = 1'b0;

endmodule
